// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage PC generator: FSM states,
// instruction size and the target alignment helper.
package pc_pkg;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    PEND = 1'b1
  } pc_state_e;

  localparam int INSTR_BYTES = 4;

  // Works on a 64-bit container so every XLEN can share it.
  function automatic logic [63:0] align_pc(input logic [63:0] addr);
    return addr & ~64'h3;
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC generator with delay-slot or flush redirect handling,
// stall-latched redirects and exception redirects.
module pc_fetch_ctrl
  import pc_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(32'h0000_3000),
  parameter bit              DELAY_SLOT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            redir_d,
  input  logic [XLEN-1:0] redir_tgt_d,
  input  logic            exc_valid,
  input  logic [XLEN-1:0] exc_tgt,
  output logic [XLEN-1:0] pc_f,
  output logic [XLEN-1:0] pc_plus4_f,
  output logic            flush_f,
  output logic            redir_pend
);

  localparam logic REDIR_FLUSH = ~DELAY_SLOT;

  pc_state_e       r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, w_pc_nxt;
  logic [XLEN-1:0] r_pend_tgt, w_pend_tgt_nxt;
  logic            r_held, w_held_nxt;
  logic            r_flush, w_flush_nxt;
  logic [XLEN-1:0] w_redir_tgt_al;
  logic [XLEN-1:0] w_exc_tgt_al;
  logic            w_new_redir;

  assign w_redir_tgt_al = XLEN'(align_pc(64'(redir_tgt_d)));
  assign w_exc_tgt_al   = XLEN'(align_pc(64'(exc_tgt)));
  // A redirect already applied stays ignored until redir_d drops.
  assign w_new_redir    = redir_d & ~r_held;

  // Next-state, next-PC and flush decision.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_pend_tgt_nxt = r_pend_tgt;
    w_held_nxt     = r_held & redir_d;
    w_flush_nxt    = 1'b0;
    if (exc_valid) begin
      w_pc_nxt       = w_exc_tgt_al;
      w_flush_nxt    = 1'b1;
      w_state_nxt    = RUN;
      w_pend_tgt_nxt = '0;
      w_held_nxt     = redir_d;
    end else begin
      case (r_state)
        PEND: begin
          if (en) begin
            w_pc_nxt    = r_pend_tgt;
            w_flush_nxt = REDIR_FLUSH;
            w_state_nxt = RUN;
            w_held_nxt  = redir_d;
          end else begin
            w_state_nxt = PEND;
          end
        end
        RUN: begin
          if (en && w_new_redir) begin
            w_pc_nxt    = w_redir_tgt_al;
            w_flush_nxt = REDIR_FLUSH;
            w_held_nxt  = 1'b1;
          end else if (en) begin
            w_pc_nxt = r_pc + XLEN'(INSTR_BYTES);
          end else if (w_new_redir) begin
            w_pend_tgt_nxt = w_redir_tgt_al;
            w_state_nxt    = PEND;
          end else begin
            w_state_nxt = RUN;
          end
        end
        default: begin
          w_state_nxt = RUN;
        end
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RUN;
      r_pc       <= RESET_VEC;
      r_pend_tgt <= '0;
      r_held     <= 1'b0;
      r_flush    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_pend_tgt <= w_pend_tgt_nxt;
      r_held     <= w_held_nxt;
      r_flush    <= w_flush_nxt;
    end
  end

  assign pc_f       = r_pc;
  assign pc_plus4_f = r_pc + XLEN'(INSTR_BYTES);
  assign flush_f    = r_flush;
  assign redir_pend = (r_state == PEND);

endmodule
